// File: rtl/motoro3_ramp_ctrl.sv
// motoro3_ramp_ctrl: speed/direction sequencer in front of the 3-phase core.
// Paced INC/DEC ramps, ramp-down before reversal, emergency brake.
module motoro3_ramp_ctrl #(
    parameter int RAMP_DIV  = 10000,
    parameter int FREQ_MIN  = 1,
    parameter int FREQ_MAX  = 1000,
    parameter int BRAKE_CYC = 100000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [9:0] cmdFreq,
    input  logic       cmdInv,
    input  logic       cmdStop,
    input  logic       estop,
    output logic       m3start,
    output logic       m3forceStop,
    output logic       m3invRotate,
    output logic       m3freqINC,
    output logic       m3freqDEC,
    output logic [9:0] curFreq,
    output logic       cmdErr,
    output logic [2:0] state
);

    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int BW = $clog2(BRAKE_CYC + 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [BW-1:0] BRAKE_LAST = BW'(BRAKE_CYC - 1);
    localparam logic [9:0] F_MIN = 10'(FREQ_MIN);
    localparam logic [9:0] F_MAX = 10'(FREQ_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RAMP  = 3'd2,
        RUN   = 3'd3,
        REV   = 3'd4,
        STOP  = 3'd5,
        BRAKE = 3'd6
    } stateT;

    stateT stateQ, stateD;

    logic [RW-1:0] rampCnt, rampCntD;
    logic [BW-1:0] brakeCnt, brakeCntD;
    logic [9:0] tgt, tgtD;
    logic [9:0] pendTgt, pendTgtD;
    logic [9:0] curD;
    logic startD, fstopD, invD, incD, decD, errD;
    logic accept, badFreq, stepTick, brakeDone, inRamp;

    assign state     = stateQ;
    assign cmdReady  = (stateQ == IDLE || stateQ == RUN) && !estop;
    assign accept    = cmdValid && cmdReady;
    assign badFreq   = !cmdStop && (cmdFreq < F_MIN || cmdFreq > F_MAX);
    assign stepTick  = rampCnt == RAMP_LAST;
    assign brakeDone = (brakeCnt == BRAKE_LAST) && !estop;
    assign inRamp    = stateQ == RAMP || stateQ == REV || stateQ == STOP;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        if (estop && stateQ != BRAKE) begin
            stateD = BRAKE;
        end else begin
            unique case (stateQ)
                IDLE: begin
                    if (accept && !cmdStop && !badFreq) stateD = START;
                end
                START: stateD = RAMP;
                RAMP: begin
                    if (curFreq == tgt) stateD = RUN;
                end
                RUN: begin
                    if (accept && !badFreq) begin
                        if (cmdStop) stateD = STOP;
                        else if (cmdInv == m3invRotate) stateD = RAMP;
                        else stateD = REV;
                    end
                end
                REV: begin
                    if (curFreq == F_MIN) stateD = RAMP;
                end
                STOP: begin
                    if (curFreq == F_MIN) stateD = IDLE;
                end
                BRAKE: begin
                    if (brakeDone) stateD = IDLE;
                end
                default: stateD = IDLE;
            endcase
        end
    end

    // pacing restarts whenever a ramping state is (re)entered
    always_comb begin
        rampCntD = '0;
        if (inRamp && stateD == stateQ) begin
            rampCntD = stepTick ? '0 : rampCnt + 1'b1;
        end
        brakeCntD = '0;
        if (stateQ == BRAKE) begin
            brakeCntD = (brakeCnt == BRAKE_LAST) ? brakeCnt : brakeCnt + 1'b1;
        end
    end

    always_comb begin
        startD   = m3start;
        fstopD   = m3forceStop;
        invD     = m3invRotate;
        incD     = 1'b0;
        decD     = 1'b0;
        curD     = curFreq;
        errD     = 1'b0;
        tgtD     = tgt;
        pendTgtD = pendTgt;
        if (estop && stateQ != BRAKE) begin
            fstopD = 1'b1;
            startD = 1'b0;
            curD   = '0;
        end else begin
            unique case (stateQ)
                IDLE: begin
                    if (accept && !cmdStop) begin
                        if (badFreq) begin
                            errD = 1'b1;
                        end else begin
                            tgtD = cmdFreq;
                            invD = cmdInv;
                        end
                    end
                end
                START: begin
                    startD = 1'b1;
                    curD   = F_MIN;
                end
                RAMP: begin
                    if (curFreq != tgt && stepTick) begin
                        if (curFreq < tgt) begin
                            incD = 1'b1;
                            curD = curFreq + 1'b1;
                        end else begin
                            decD = 1'b1;
                            curD = curFreq - 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (badFreq) begin
                            errD = 1'b1;
                        end else if (!cmdStop) begin
                            if (cmdInv == m3invRotate) tgtD = cmdFreq;
                            else pendTgtD = cmdFreq;
                        end
                    end
                end
                REV: begin
                    if (curFreq == F_MIN) begin
                        invD = !m3invRotate;
                        tgtD = pendTgt;
                    end else if (stepTick) begin
                        decD = 1'b1;
                        curD = curFreq - 1'b1;
                    end
                end
                STOP: begin
                    if (curFreq == F_MIN) begin
                        startD = 1'b0;
                        curD   = '0;
                    end else if (stepTick) begin
                        decD = 1'b1;
                        curD = curFreq - 1'b1;
                    end
                end
                BRAKE: begin
                    if (brakeDone) fstopD = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            m3start     <= 1'b0;
            m3forceStop <= 1'b0;
            m3invRotate <= 1'b0;
            m3freqINC   <= 1'b0;
            m3freqDEC   <= 1'b0;
            curFreq     <= '0;
            cmdErr      <= 1'b0;
            tgt         <= '0;
            pendTgt     <= '0;
            rampCnt     <= '0;
            brakeCnt    <= '0;
        end else begin
            m3start     <= startD;
            m3forceStop <= fstopD;
            m3invRotate <= invD;
            m3freqINC   <= incD;
            m3freqDEC   <= decD;
            curFreq     <= curD;
            cmdErr      <= errD;
            tgt         <= tgtD;
            pendTgt     <= pendTgtD;
            rampCnt     <= rampCntD;
            brakeCnt    <= brakeCntD;
        end
    end

endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// tb_motoro3_ramp_ctrl: randomized scenarios against an arithmetic
// model of the ramp schedule (pulse every RAMP_DIV edges per phase).
module tb_motoro3_ramp_ctrl;

    localparam int RD   = 4;
    localparam int BC   = 8;
    localparam int FMIN = 1;
    localparam int FMAX = 1000;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic cmdValid = 1'b0;
    logic cmdInv = 1'b0;
    logic cmdStop = 1'b0;
    logic estop = 1'b0;
    logic [9:0] cmdFreq = '0;
    logic cmdReady, m3start, m3forceStop, m3invRotate;
    logic m3freqINC, m3freqDEC, cmdErr;
    logic [9:0] curFreq;
    logic [2:0] state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int obsEdge[$];
    bit obsInc[$];
    int expEdge[$];
    bit expInc[$];
    int hsCount = 0;
    int errCount = 0;
    int fsCount = 0;
    int startLows = 0;
    int lastPulse = -1000;
    int prevCur = 0;
    int modelFreq = 0;
    bit modelInv = 1'b0;

    motoro3_ramp_ctrl #(
        .RAMP_DIV(RD),
        .FREQ_MIN(FMIN),
        .FREQ_MAX(FMAX),
        .BRAKE_CYC(BC)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .cmdValid(cmdValid),
        .cmdReady(cmdReady),
        .cmdFreq(cmdFreq),
        .cmdInv(cmdInv),
        .cmdStop(cmdStop),
        .estop(estop),
        .m3start(m3start),
        .m3forceStop(m3forceStop),
        .m3invRotate(m3invRotate),
        .m3freqINC(m3freqINC),
        .m3freqDEC(m3freqDEC),
        .curFreq(curFreq),
        .cmdErr(cmdErr),
        .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // invariants and event log, sampled mid-cycle
    always @(negedge clk) begin
        if (!nRst) begin
            lastPulse = -1000;
            prevCur = 0;
        end else begin
            if (m3freqINC && m3freqDEC) begin
                total++; bad++;
                $display("FAIL inc_dec_both got=1 want=0 edge=%0d", cyc);
            end
            if (m3freqINC || m3freqDEC) begin
                total++;
                if (cyc - lastPulse < RD) begin
                    bad++;
                    $display("FAIL pulse_gap got=%0d want>=%0d", cyc - lastPulse, RD);
                end
                total++;
                if (int'(curFreq) != (m3freqINC ? prevCur + 1 : prevCur - 1)) begin
                    bad++;
                    $display("FAIL pulse_step got=%0d prev=%0d inc=%0d", curFreq, prevCur, m3freqINC);
                end
                obsEdge.push_back(cyc);
                obsInc.push_back(m3freqINC);
                lastPulse = cyc;
            end
            if (m3start) begin
                total++;
                if (curFreq < FMIN || curFreq > FMAX) begin
                    bad++;
                    $display("FAIL freq_range got=%0d want=[%0d,%0d]", curFreq, FMIN, FMAX);
                end
            end
            if (cmdReady && estop) begin
                total++; bad++;
                $display("FAIL ready_in_estop got=1 want=0 edge=%0d", cyc);
            end
            if (cmdValid && cmdReady) hsCount++;
            if (cmdErr) errCount++;
            if (m3forceStop) fsCount++;
            if (!m3start) startLows++;
            prevCur = int'(curFreq);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int addRamp(input int startEdge, input int from, input int to);
        int n;
        n = (from > to) ? from - to : to - from;
        for (int k = 1; k <= n; k++) begin
            expEdge.push_back(startEdge + RD * k);
            expInc.push_back(to > from);
        end
        return startEdge + RD * n + 1;
    endfunction

    task automatic runTo(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendCmd(input logic [9:0] f, input logic inv, input logic stp,
                           output int accEdge, output bit ok);
        ok = 1'b0;
        accEdge = -1;
        cmdFreq = f;
        cmdInv = inv;
        cmdStop = stp;
        cmdValid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (cmdReady) begin
                ok = 1'b1;
                accEdge = cyc + 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        cmdStop = 1'b0;
    endtask

    task automatic test_reset();
        int a;
        bit ok;
        int f;
        repeat (2) @(posedge clk);
        #1;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
        total++; if ({m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC, cmdErr} !== 6'd0) begin
            bad++; $display("FAIL rst_ctrl got=%b want=000000", {m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC, cmdErr});
        end
        total++; if (curFreq !== 10'd0) begin bad++; $display("FAIL rst_freq got=%0d want=0", curFreq); end
        nRst = 1'b1;
        #1;
        total++; if (cmdReady !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0d want=1", cmdReady); end
        f = $urandom_range(4, 9);
        sendCmd(10'(f), 1'b1, 1'b0, a, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_hs got=0 want=1"); end
        runTo(a + 1 + RD + 1);
        total++; if (curFreq !== 10'd2) begin bad++; $display("FAIL rst_midramp got=%0d want=2", curFreq); end
        #2;
        nRst = 1'b0;
        #1;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst2_state got=%0d want=0", state); end
        total++; if ({m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC, cmdErr} !== 6'd0) begin
            bad++; $display("FAIL rst2_ctrl got=%b want=000000", {m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC, cmdErr});
        end
        total++; if (curFreq !== 10'd0) begin bad++; $display("FAIL rst2_freq got=%0d want=0", curFreq); end
        @(posedge clk);
        #1;
        nRst = 1'b1;
        #1;
        total++; if (cmdReady !== 1'b1) begin bad++; $display("FAIL rst2_ready got=%0d want=1", cmdReady); end
        modelFreq = 0;
        modelInv = 1'b0;
    endtask

    task automatic test_start(input int f, input bit inv);
        int a;
        int endE;
        bit ok;
        obsEdge.delete(); obsInc.delete(); expEdge.delete(); expInc.delete();
        sendCmd(10'(f), inv, 1'b0, a, ok);
        total++; if (!ok) begin bad++; $display("FAIL start_hs got=0 want=1"); end
        runTo(a);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL start_state got=%0d want=1", state); end
        total++; if (m3invRotate !== inv) begin bad++; $display("FAIL start_inv got=%0d want=%0d", m3invRotate, inv); end
        runTo(a + 1);
        total++; if (m3start !== 1'b1) begin bad++; $display("FAIL start_m3start got=%0d want=1", m3start); end
        total++; if (curFreq !== 10'(FMIN)) begin bad++; $display("FAIL start_fmin got=%0d want=%0d", curFreq, FMIN); end
        endE = addRamp(a + 1, FMIN, f);
        runTo(endE - 1);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL start_ramp got=%0d want=2", state); end
        runTo(endE);
        total++; if (state !== 3'd3) begin bad++; $display("FAIL start_run got=%0d want=3", state); end
        total++; if (curFreq !== 10'(f)) begin bad++; $display("FAIL start_freq got=%0d want=%0d", curFreq, f); end
        runTo(endE + 1);
        total++;
        if (obsEdge.size() != expEdge.size()) begin
            bad++; $display("FAIL start_npulse got=%0d want=%0d", obsEdge.size(), expEdge.size());
        end else begin
            foreach (expEdge[i]) begin
                total++;
                if (obsEdge[i] !== expEdge[i] || obsInc[i] !== expInc[i]) begin
                    bad++; $display("FAIL start_pulse got=%0d/%0d want=%0d/%0d", obsEdge[i], obsInc[i], expEdge[i], expInc[i]);
                end
            end
        end
        modelFreq = f;
        modelInv = inv;
    endtask

    // kind: 0 retarget, 1 reversal, 2 controlled stop
    task automatic test_run_cmd(input int kind, input int t, input bit inv);
        int a;
        int r;
        int endE;
        int f;
        int expSt;
        bit oldInv;
        bit ok;
        f = modelFreq;
        oldInv = modelInv;
        expSt = (kind == 0) ? 2 : ((kind == 1) ? 4 : 5);
        obsEdge.delete(); obsInc.delete(); expEdge.delete(); expInc.delete();
        startLows = 0;
        sendCmd(10'(t), inv, kind == 2, a, ok);
        total++; if (!ok) begin bad++; $display("FAIL cmd%0d_hs got=0 want=1", kind); end
        runTo(a);
        total++; if (int'(state) != expSt) begin bad++; $display("FAIL cmd%0d_state got=%0d want=%0d", kind, state, expSt); end
        total++; if (m3invRotate !== oldInv) begin bad++; $display("FAIL cmd%0d_inv0 got=%0d want=%0d", kind, m3invRotate, oldInv); end
        if (kind == 1) begin
            r = addRamp(a, f, FMIN);
            runTo(r);
            total++; if (state !== 3'd2) begin bad++; $display("FAIL rev_ramp got=%0d want=2", state); end
            total++; if (m3invRotate !== !oldInv) begin bad++; $display("FAIL rev_inv got=%0d want=%0d", m3invRotate, !oldInv); end
            total++; if (curFreq !== 10'(FMIN)) begin bad++; $display("FAIL rev_fmin got=%0d want=%0d", curFreq, FMIN); end
            endE = addRamp(r, FMIN, t);
        end else if (kind == 0) begin
            endE = addRamp(a, f, t);
        end else begin
            endE = addRamp(a, f, FMIN);
        end
        runTo(endE);
        if (kind == 2) begin
            total++; if (state !== 3'd0) begin bad++; $display("FAIL stop_state got=%0d want=0", state); end
            total++; if (m3start !== 1'b0) begin bad++; $display("FAIL stop_m3start got=%0d want=0", m3start); end
            total++; if (curFreq !== 10'd0) begin bad++; $display("FAIL stop_freq got=%0d want=0", curFreq); end
        end else begin
            total++; if (state !== 3'd3) begin bad++; $display("FAIL cmd%0d_run got=%0d want=3", kind, state); end
            total++; if (curFreq !== 10'(t)) begin bad++; $display("FAIL cmd%0d_freq got=%0d want=%0d", kind, curFreq, t); end
            total++; if (m3invRotate !== inv) begin bad++; $display("FAIL cmd%0d_inv got=%0d want=%0d", kind, m3invRotate, inv); end
        end
        runTo(endE + 1);
        if (kind != 2) begin
            total++; if (startLows != 0) begin bad++; $display("FAIL cmd%0d_startdrop got=%0d want=0", kind, startLows); end
        end
        total++;
        if (obsEdge.size() != expEdge.size()) begin
            bad++; $display("FAIL cmd%0d_npulse got=%0d want=%0d", kind, obsEdge.size(), expEdge.size());
        end else begin
            foreach (expEdge[i]) begin
                total++;
                if (obsEdge[i] !== expEdge[i] || obsInc[i] !== expInc[i]) begin
                    bad++; $display("FAIL cmd%0d_pulse got=%0d/%0d want=%0d/%0d", kind, obsEdge[i], obsInc[i], expEdge[i], expInc[i]);
                end
            end
        end
        modelFreq = (kind == 2) ? 0 : t;
        modelInv = (kind == 2) ? oldInv : inv;
    endtask

    task automatic test_estop();
        int a;
        int e;
        int f;
        bit inv;
        bit ok;
        f = $urandom_range(5, 9);
        inv = 1'($urandom_range(0, 1));
        sendCmd(10'(f), inv, 1'b0, a, ok);
        total++; if (!ok) begin bad++; $display("FAIL estop_hs0 got=0 want=1"); end
        runTo(a + 1 + RD + 2);
        hsCount = 0;
        fsCount = 0;
        e = cyc + 1;
        estop = 1'b1;
        cmdValid = 1'b1;
        cmdFreq = 10'd3;
        cmdInv = inv;
        cmdStop = 1'b0;
        runTo(e);
        total++; if (state !== 3'd6) begin bad++; $display("FAIL estop_state got=%0d want=6", state); end
        total++; if ({m3forceStop, m3start, m3freqINC, m3freqDEC} !== 4'b1000) begin
            bad++; $display("FAIL estop_ctrl got=%b want=1000", {m3forceStop, m3start, m3freqINC, m3freqDEC});
        end
        total++; if (curFreq !== 10'd0) begin bad++; $display("FAIL estop_freq got=%0d want=0", curFreq); end
        runTo(e + 2);
        estop = 1'b0;
        runTo(e + 7);
        total++; if (state !== 3'd6 || m3forceStop !== 1'b1) begin
            bad++; $display("FAIL brake_hold got=%0d/%0d want=6/1", state, m3forceStop);
        end
        cmdValid = 1'b0;
        runTo(e + 8);
        total++; if (state !== 3'd0 || m3forceStop !== 1'b0) begin
            bad++; $display("FAIL brake_exit got=%0d/%0d want=0/0", state, m3forceStop);
        end
        runTo(e + 9);
        total++; if (fsCount != BC) begin bad++; $display("FAIL brake_len got=%0d want=%0d", fsCount, BC); end
        total++; if (hsCount != 0) begin bad++; $display("FAIL brake_hs got=%0d want=0", hsCount); end
        total++; if (m3invRotate !== inv) begin bad++; $display("FAIL brake_inv got=%0d want=%0d", m3invRotate, inv); end
        modelFreq = 0;
        modelInv = inv;
    endtask

    task automatic test_errors();
        int a;
        bit ok;
        errCount = 0;
        sendCmd(10'd0, 1'b0, 1'b0, a, ok);
        runTo(a);
        total++; if (!ok || cmdErr !== 1'b1 || state !== 3'd0) begin
            bad++; $display("FAIL err_idle got=%0d/%0d/%0d want=1/1/0", ok, cmdErr, state);
        end
        sendCmd(10'd7, !modelInv, 1'b1, a, ok);
        runTo(a);
        total++; if (!ok || cmdErr !== 1'b0 || state !== 3'd0 || m3invRotate !== modelInv) begin
            bad++; $display("FAIL stop_idle got=%0d/%0d/%0d/%0d want=1/0/0/%0d", ok, cmdErr, state, m3invRotate, modelInv);
        end
        test_start(4, 1'($urandom_range(0, 1)));
        sendCmd(10'd0, modelInv, 1'b0, a, ok);
        runTo(a);
        total++; if (!ok || cmdErr !== 1'b1 || state !== 3'd3 || curFreq !== 10'd4) begin
            bad++; $display("FAIL err_low got=%0d/%0d/%0d/%0d want=1/1/3/4", ok, cmdErr, state, curFreq);
        end
        sendCmd(10'd1001, !modelInv, 1'b0, a, ok);
        runTo(a);
        total++; if (!ok || cmdErr !== 1'b1 || state !== 3'd3 || m3invRotate !== modelInv) begin
            bad++; $display("FAIL err_high got=%0d/%0d/%0d/%0d want=1/1/3/%0d", ok, cmdErr, state, m3invRotate, modelInv);
        end
        runTo(a + 1);
        total++; if (errCount != 3 || cmdErr !== 1'b0) begin
            bad++; $display("FAIL err_count got=%0d/%0d want=3/0", errCount, cmdErr);
        end
        test_run_cmd(2, 0, modelInv);
    endtask

    task automatic test_back_to_back();
        int kind;
        int t;
        test_start($urandom_range(1, 6), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 6; i++) begin
            kind = $urandom_range(0, 1);
            t = $urandom_range(1, 7);
            test_run_cmd(kind, t, (kind == 1) ? !modelInv : modelInv);
        end
        test_run_cmd(2, 0, modelInv);
    endtask

    initial begin
        test_reset();
        test_start(5, 1'b0);
        test_run_cmd(0, 3, 1'b0);
        test_run_cmd(1, 4, 1'b1);
        test_estop();
        test_errors();
        test_start(1, 1'b1);
        test_run_cmd(2, 0, modelInv);
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motoro3_ramp_ctrl.md
# motoro3_ramp_ctrl

Speed/direction sequencer for the 3-phase motor drive. It accepts target-frequency, direction and stop commands over a valid/ready handshake and translates them into the motor core's control inputs: `m3start`, `m3forceStop`, `m3invRotate`, and the single-cycle `m3freqINC`/`m3freqDEC` step pulses. It enforces a paced acceleration ramp, a ramp-down before any direction reversal, and an emergency brake path. It sits directly in front of the motor core, which it drives exclusively.

## Interface
- `RAMP_DIV`, 10000: clocks between consecutive INC/DEC pulses (≥2); 1 ms per Hz at 10 MHz.
- `FREQ_MIN`, 1: lowest legal frequency; the core runs at this frequency immediately after `m3start` rises.
- `FREQ_MAX`, 1000: highest legal frequency.
- `BRAKE_CYC`, 100000: minimum number of cycles `m3forceStop` is held.
- `clk`  in  1  system clock, 10 MHz.
- `nRst`  in  1  reset, asynchronous, active-low.
- `cmdValid`  in  1  command present.
- `cmdReady`  out  1  command can be accepted; transfer occurs when `cmdValid & cmdReady`.
- `cmdFreq`  in  10  target frequency, Hz.
- `cmdInv`  in  1  requested direction; 1 = inverse.
- `cmdStop`  in  1  controlled stop; `cmdFreq` and `cmdInv` are ignored when this is set.
- `estop`  in  1  emergency stop, level-sensitive.
- `m3start`, `m3forceStop`, `m3invRotate`, `m3freqINC`, `m3freqDEC`  out  1 each  motor-core controls, all registered.
- `curFreq`  out  10  frequency the core is currently commanded to; 0 when stopped.
- `cmdErr`  out  1  one-cycle pulse when an accepted command is rejected.
- `state`  out  3  current state, for debug.

## Operation
- States and encoding: IDLE=0, START=1, RAMP=2, RUN=3, REV=4, STOP=5, BRAKE=6.
- **Reset values:** state=IDLE; all `m3*` outputs 0; `curFreq`=0; `cmdErr`=0; internal target and pending registers 0.
- **cmdReady:** 1 only in IDLE or RUN, and only while `estop`=0.
- **Command validation:** with `cmdStop`=0, `cmdFreq` outside [`FREQ_MIN`, `FREQ_MAX`] is still accepted (handshake completes), but `cmdErr` pulses and all state and outputs are left unchanged.
- **IDLE**
  - A stop command is a no-op.
  - A valid command latches the target as `tgt`, sets `m3invRotate`=`cmdInv`, and moves to START.
- **START:** set `m3start`=1 and `curFreq`=`FREQ_MIN`, then move to RAMP.
- **RAMP**
  - If `curFreq`==`tgt`, move to RUN.
  - Otherwise a pacing counter (cleared on entry to RAMP, REV or STOP) runs 0..`RAMP_DIV`-1.
  - At terminal count it emits one `m3freqINC` pulse with `curFreq`+1 if `curFreq`<`tgt`, or one `m3freqDEC` pulse with `curFreq`-1 if `curFreq`>`tgt`; then it wraps.
- **RUN**
  - A valid command with the same direction sets `tgt` and moves to RAMP.
  - A valid command with the opposite direction stores the pending target and direction and moves to REV.
  - A stop command moves to STOP.
- **REV**
  - DEC-ramp at the same pace down to `FREQ_MIN`.
  - On reaching it: toggle `m3invRotate`, set `tgt`=pending target, move to RAMP.
- **STOP**
  - DEC-ramp down to `FREQ_MIN`.
  - Then `m3start`=0, `curFreq`=0, move to IDLE.
- **BRAKE**
  - `estop`=1 in any state forces BRAKE on the next edge: `m3forceStop`=1, `m3start`=0, INC/DEC=0, `curFreq`=0, brake counter cleared.
  - Exit to IDLE (with `m3forceStop`=0) once the counter has reached `BRAKE_CYC`-1 and `estop`=0.
  - `estop` has priority over everything, including a handshake in the same cycle, which is blocked by `cmdReady`=0.
- **Invariants**
  - `m3freqINC` and `m3freqDEC` are never both 1.
  - Step pulses are never adjacent: spacing is ≥`RAMP_DIV` cycles.
  - `curFreq` stays within [`FREQ_MIN`, `FREQ_MAX`] whenever `m3start`=1.
  - `m3invRotate` changes only in IDLE, or in REV at `FREQ_MIN`.

## Timing
- Command accepted at edge N in IDLE:
  - state=START and `m3invRotate` valid after edge N;
  - `m3start`=1 and `curFreq`=`FREQ_MIN` after edge N+1;
  - first step pulse after edge N+1+`RAMP_DIV`.
- Pulse width: each INC/DEC pulse is exactly 1 cycle; `curFreq` updates on the same edge that raises the pulse.
- RAMP→RUN occurs one cycle after equality is reached. If `tgt`==`FREQ_MIN`, RUN is entered at N+2.
- A command accepted in RUN enters RAMP/REV/STOP on the next edge; its first pulse comes `RAMP_DIV` cycles later.
- `estop` asserted at cycle K → BRAKE outputs valid after edge K+1.

## Test plan
Parameters for all scenarios: `RAMP_DIV`=4, `FREQ_MIN`=1, `FREQ_MAX`=1000, `BRAKE_CYC`=8.
- **Reset:** assert `nRst` low mid-ramp → all outputs 0, state=0, and `cmdReady`=1 after release.
- **Start:** cmd freq=5, inv=0 in IDLE → `m3start`=1 two edges after accept; 4 INC pulses spaced 4 cycles apart; `curFreq` steps 1→5; state=3.
- **Retarget:** in RUN at 5, send freq=3 → exactly 2 DEC pulses; `curFreq`=3; RUN; `m3invRotate` unchanged.
- **Reversal:** in RUN at 3, send inv=1, freq=4 → 2 DEC pulses to 1; `m3invRotate`=1; then 3 INC pulses to 4; `m3start` never drops.
- **Emergency stop:** assert `estop` during RAMP for 3 cycles → next edge gives `m3forceStop`=1, `m3start`=0, `curFreq`=0; `m3forceStop` held exactly 8 cycles; then IDLE; no handshake completes meanwhile.
- **Errors and stop:** cmd freq=0, then freq=1001 → `cmdErr` pulses once each, state unchanged. Then `cmdStop` from RUN at 4 → 3 DEC pulses; `m3start`=0; `curFreq`=0; IDLE.
